// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, FSM state encodings and the saturating adder used by
// the mac_pe accumulator.
//   ST_IDLE / ST_RUN : vector-sequencer states
//   sat_add()        : w-bit add with signed/unsigned overflow detect and optional clamp
package mac_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 24;
  localparam int unsigned MAX_LEN_DEF    = 8;

  // Working width of sat_add; accumulator widths must stay below this.
  localparam int unsigned SAT_W = 64;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             ovf;
  } sat_res_t;

  // Adds two w-bit values held zero-extended in SAT_W bits. The sum comes back
  // masked to w bits; on overflow with saturate set it is clamped instead.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input logic             is_signed,
                                       input logic             saturate,
                                       input int unsigned      w);
    logic [SAT_W-1:0] full;
    logic [SAT_W-1:0] mask;
    logic [SAT_W-1:0] sbit;
    logic             a_msb;
    logic             b_msb;
    logic             s_msb;
    logic             carry;
    sat_res_t         r;
    mask  = (SAT_W'(1) << w) - SAT_W'(1);
    sbit  = SAT_W'(1) << (w - 1);
    full  = a + b;
    a_msb = |(a & sbit);
    b_msb = |(b & sbit);
    s_msb = |(full & sbit);
    carry = |(full & (sbit << 1));
    r.ovf = is_signed ? ((a_msb == b_msb) && (s_msb != a_msb)) : carry;
    r.sum = full & mask;
    if (r.ovf && saturate) begin
      if (is_signed) r.sum = a_msb ? sbit : (sbit - SAT_W'(1));
      else           r.sum = mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: registered multiply stage of the MAC PE.
//   valid_i/first_i/last_i/signed_i : element tags from the sequencer
//   a_i, b_i                        : operands
//   p_*_o                           : registered tags and product, product
//                                     sign/zero-extended to ACC_WIDTH
module mac_mult_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  p_valid_o,
  output logic                  p_first_o,
  output logic                  p_last_o,
  output logic                  p_signed_o,
  output logic [ACC_WIDTH-1:0]  p_data_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]    prod_s;
  logic        [PW-1:0]    prod_u;
  logic        [ACC_WIDTH-1:0] ext_s;
  logic        [ACC_WIDTH-1:0] ext_u;
  logic        [ACC_WIDTH-1:0] p_data_d;

  logic                 p_valid_q, p_first_q, p_last_q, p_signed_q;
  logic [ACC_WIDTH-1:0] p_data_q;

  // Both products are formed; the sign mode of the element picks one.
  always_comb begin
    prod_s   = PW'($signed(a_i)) * PW'($signed(b_i));
    prod_u   = PW'(a_i) * PW'(b_i);
    ext_s    = ACC_WIDTH'(prod_s);
    ext_u    = ACC_WIDTH'(prod_u);
    p_data_d = signed_i ? ext_s : ext_u;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q  <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      p_signed_q <= 1'b0;
      p_data_q   <= '0;
    end else begin
      p_valid_q  <= valid_i;
      p_first_q  <= first_i;
      p_last_q   <= last_i;
      p_signed_q <= signed_i;
      p_data_q   <= p_data_d;
    end
  end

  assign p_valid_o  = p_valid_q;
  assign p_first_o  = p_first_q;
  assign p_last_o   = p_last_q;
  assign p_signed_o = p_signed_q;
  assign p_data_o   = p_data_q;

endmodule

// File: rtl/mac_pe.sv
// mac_pe: pipelined multiply-accumulate processing element for the systolic
// array. Counts elements into vectors, accumulates with optional saturation,
// and emits one result pulse per vector.
//   clr                     : synchronous clear of all accumulation state
//   in_valid, a_in, b_in    : input element
//   vec_len, signed_mode    : vector config, sampled on a vector's first element
//   a_out, b_out, valid_out : one-cycle forwarding to the neighbouring PE
//   acc_out, result_valid   : last vector sum and its one-cycle update pulse
//   result_ovf, ovf_sticky  : per-result and since-clear overflow flags
//   busy                    : vector in progress or element in the pipeline
module mac_pe
  import mac_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter  int unsigned MAX_LEN    = MAX_LEN_DEF,
  parameter  int unsigned SATURATE   = 1,
  localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [LEN_W-1:0]      vec_len,
  input  logic                  signed_mode,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  valid_out,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  result_valid,
  output logic                  result_ovf,
  output logic                  ovf_sticky,
  output logic                  busy
);

  localparam logic SAT_EN = (SATURATE != 0);

  // Sequencer state
  logic [0:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             sign_q, sign_d;
  logic [LEN_W-1:0] len_eff;
  logic             first_c, last_c, elem_sign_c, accept_c;

  // Pass-through
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  valid_q;

  // Stage 1 outputs
  logic                 p_valid, p_first, p_last, p_signed;
  logic [ACC_WIDTH-1:0] p_data;

  // Stage 2 state
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                 vec_ovf_q, vec_ovf_d;
  logic                 sticky_q, sticky_d;
  logic                 res_ovf_q, res_ovf_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;

  logic [ACC_WIDTH-1:0] acc_base_c, sum_c;
  logic                 hold_c, ovf_c;
  sat_res_t             sr;
  logic                 unused_sum_hi;

  // Effective length: 0 means 1, anything above MAX_LEN is clamped.
  always_comb begin
    len_eff = vec_len;
    if (vec_len == '0)                     len_eff = LEN_W'(1);
    else if (vec_len > LEN_W'(MAX_LEN))    len_eff = LEN_W'(MAX_LEN);
  end

  assign accept_c = in_valid & ~clr;

  // Vector sequencer: tags first/last elements and latches per-vector config.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sign_d      = sign_q;
    first_c     = 1'b0;
    last_c      = 1'b0;
    elem_sign_c = sign_q;
    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (in_valid) begin
      if (state_q == ST_IDLE) begin
        first_c     = 1'b1;
        len_d       = len_eff;
        sign_d      = signed_mode;
        elem_sign_c = signed_mode;
        count_d     = LEN_W'(1);
        if (len_eff == LEN_W'(1)) last_c  = 1'b1;
        else                      state_d = ST_RUN;
      end else begin
        if (count_q + LEN_W'(1) == len_q) begin
          last_c  = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sign_q  <= sign_d;
    end
  end

  // Forwarding registers ignore clr and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_in;
      b_q     <= b_in;
      valid_q <= in_valid;
    end
  end

  mac_mult_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mult (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (accept_c),
    .first_i    (first_c),
    .last_i     (last_c),
    .signed_i   (elem_sign_c),
    .a_i        (a_in),
    .b_i        (b_in),
    .p_valid_o  (p_valid),
    .p_first_o  (p_first),
    .p_last_o   (p_last),
    .p_signed_o (p_signed),
    .p_data_o   (p_data)
  );

  // Accumulate stage. Once a saturating vector has overflowed, the clamped
  // value is held for the rest of that vector.
  always_comb begin
    acc_base_c    = p_first ? '0 : acc_q;
    sr            = sat_add(SAT_W'(acc_base_c), SAT_W'(p_data), p_signed, SAT_EN, ACC_WIDTH);
    unused_sum_hi = ^sr.sum[SAT_W-1:ACC_WIDTH];
    hold_c        = SAT_EN && vec_ovf_q && !p_first;
    sum_c         = hold_c ? acc_q : sr.sum[ACC_WIDTH-1:0];
    ovf_c         = !hold_c && sr.ovf;

    acc_d       = acc_q;
    vec_ovf_d   = vec_ovf_q;
    sticky_d    = sticky_q;
    acc_out_d   = acc_out_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = 1'b0;
    if (clr) begin
      acc_d     = '0;
      vec_ovf_d = 1'b0;
      sticky_d  = 1'b0;
      acc_out_d = '0;
      res_ovf_d = 1'b0;
    end else if (p_valid) begin
      acc_d     = sum_c;
      vec_ovf_d = (vec_ovf_q & ~p_first) | ovf_c;
      sticky_d  = sticky_q | ovf_c;
      if (p_last) begin
        acc_out_d   = sum_c;
        res_ovf_d   = vec_ovf_d;
        res_valid_d = 1'b1;
      end
    end
    busy_d = (state_d == ST_RUN) | accept_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      vec_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
      acc_out_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      vec_ovf_q   <= vec_ovf_d;
      sticky_q    <= sticky_d;
      acc_out_q   <= acc_out_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign valid_out    = valid_q;
  assign acc_out      = acc_out_q;
  assign result_valid = res_valid_q;
  assign result_ovf   = res_ovf_q;
  assign ovf_sticky   = sticky_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed-vector bench for mac_pe. Three instances share the
// stimulus: default widths, 16-bit accumulator saturating, 16-bit wrapping.
module tb_mac_pe;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] a_in, b_in;
  logic [3:0] vec_len;
  logic       signed_mode;

  logic [7:0]  m_a_out, m_b_out, s_a_out, s_b_out, w_a_out, w_b_out;
  logic        m_valid_out, s_valid_out, w_valid_out;
  logic [23:0] m_acc_out;
  logic [15:0] s_acc_out, w_acc_out;
  logic        m_result_valid, s_result_valid, w_result_valid;
  logic        m_result_ovf, s_result_ovf, w_result_ovf;
  logic        m_ovf_sticky, s_ovf_sticky, w_ovf_sticky;
  logic        m_busy, s_busy, w_busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc    = 0;
  logic [23:0] acc_log[$];
  int          pcyc[$];

  mac_pe u_main (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .vec_len(vec_len), .signed_mode(signed_mode),
    .a_out(m_a_out), .b_out(m_b_out), .valid_out(m_valid_out),
    .acc_out(m_acc_out), .result_valid(m_result_valid), .result_ovf(m_result_ovf),
    .ovf_sticky(m_ovf_sticky), .busy(m_busy)
  );

  mac_pe #(.ACC_WIDTH(16), .SATURATE(1)) u_sat16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .vec_len(vec_len), .signed_mode(signed_mode),
    .a_out(s_a_out), .b_out(s_b_out), .valid_out(s_valid_out),
    .acc_out(s_acc_out), .result_valid(s_result_valid), .result_ovf(s_result_ovf),
    .ovf_sticky(s_ovf_sticky), .busy(s_busy)
  );

  mac_pe #(.ACC_WIDTH(16), .SATURATE(0)) u_wrap16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .vec_len(vec_len), .signed_mode(signed_mode),
    .a_out(w_a_out), .b_out(w_b_out), .valid_out(w_valid_out),
    .acc_out(w_acc_out), .result_valid(w_result_valid), .result_ovf(w_result_ovf),
    .ovf_sticky(w_ovf_sticky), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every result pulse of the default instance.
  always @(negedge clk) begin
    if (m_result_valid) begin
      pulses = pulses + 1;
      acc_log.push_back(m_acc_out);
      pcyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] len, input logic sg);
    @(negedge clk);
    in_valid    = v;
    a_in        = a;
    b_in        = b;
    vec_len     = len;
    signed_mode = sg;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Cycles from the last accepted element to result_valid; 0 on timeout.
  task automatic wait_result(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (m_result_valid) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int base;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    a_in = '0; b_in = '0; vec_len = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc",    64'(m_acc_out), 64'd0);
    chk("rst_rv",     64'(m_result_valid), 64'd0);
    chk("rst_busy",   64'(m_busy), 64'd0);
    chk("rst_vout",   64'(m_valid_out), 64'd0);
    chk("rst_sticky", 64'(m_ovf_sticky), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Unsigned 255*255 x8: 520200, no overflow in 24 bits
    base = pulses;
    for (int i = 0; i < 8; i++) drive(1'b1, 8'd255, 8'd255, 4'd8, 1'b0);
    wait_result(n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_acc",     64'(m_acc_out), 64'd520200);
    chk("t1_ovf",     64'(m_result_ovf), 64'd0);
    idle(1);
    chk("t1_rv_pulse", 64'(m_result_valid), 64'd0);
    chk("t1_acc_hold", 64'(m_acc_out), 64'd520200);
    idle(2);
    chk("t1_pulses", 64'(pulses - base), 64'd1);

    // Clear the 16-bit instances, which overflowed above
    @(negedge clk); clr = 1'b1; in_valid = 1'b0;
    @(negedge clk); clr = 1'b0;
    chk("clr_acc_out", 64'(m_acc_out), 64'd0);
    chk("clr_sticky",  64'(s_ovf_sticky), 64'd0);

    // Signed len 4, sign sampled on first element only: -15+14+1-8 = -8
    drive(1'b1, 8'hFD, 8'd5,  4'd4, 1'b1);
    drive(1'b1, 8'd2,  8'd7,  4'd1, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 4'd1, 1'b0);
    drive(1'b1, 8'd4,  8'hFE, 4'd1, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    chk("t2_busy_pipe", 64'(m_busy), 64'd1);
    @(negedge clk);
    chk("t2_rv",    64'(m_result_valid), 64'd1);
    chk("t2_acc",   64'(m_acc_out), 64'hFFFFF8);
    chk("t2_acc16", 64'(s_acc_out), 64'hFFF8);
    chk("t2_ovf",   64'(m_result_ovf), 64'd0);
    idle(2);
    chk("t2_busy_done", 64'(m_busy), 64'd0);

    // Unsigned 255*255 x2: 130050 overflows 16 bits
    drive(1'b1, 8'd255, 8'd255, 4'd2, 1'b0);
    drive(1'b1, 8'd255, 8'd255, 4'd2, 1'b0);
    wait_result(n);
    chk("t3_latency",   64'(n), 64'd2);
    chk("t3_acc24",     64'(m_acc_out), 64'h1FC02);
    chk("t3_ovf24",     64'(m_result_ovf), 64'd0);
    chk("t3_sat_acc",   64'(s_acc_out), 64'hFFFF);
    chk("t3_sat_ovf",   64'(s_result_ovf), 64'd1);
    chk("t3_sat_stk",   64'(s_ovf_sticky), 64'd1);
    chk("t3_wrap_acc",  64'(w_acc_out), 64'hFC02);
    chk("t3_wrap_ovf",  64'(w_result_ovf), 64'd1);

    // Signed 16384+16384 overflows 16 bits, then -16256: saturation holds
    drive(1'b1, 8'h80, 8'h80, 4'd3, 1'b1);
    drive(1'b1, 8'h80, 8'h80, 4'd3, 1'b1);
    drive(1'b1, 8'h80, 8'h7F, 4'd3, 1'b1);
    wait_result(n);
    chk("t3s_latency",  64'(n), 64'd2);
    chk("t3s_acc24",    64'(m_acc_out), 64'h004080);
    chk("t3s_ovf24",    64'(m_result_ovf), 64'd0);
    chk("t3s_sat_acc",  64'(s_acc_out), 64'h7FFF);
    chk("t3s_sat_ovf",  64'(s_result_ovf), 64'd1);
    chk("t3s_wrap_acc", 64'(w_acc_out), 64'h4080);
    chk("t3s_wrap_ovf", 64'(w_result_ovf), 64'd1);

    // Back-to-back vectors of length 2
    idle(1);
    base = pulses;
    drive(1'b1, 8'd1, 8'd1, 4'd2, 1'b0);
    drive(1'b1, 8'd2, 8'd2, 4'd2, 1'b0);
    drive(1'b1, 8'd3, 8'd3, 4'd2, 1'b0);
    drive(1'b1, 8'd4, 8'd4, 4'd2, 1'b0);
    idle(4);
    chk("t4_pulses", 64'(pulses - base), 64'd2);
    if (pulses - base >= 2) begin
      chk("t4_acc0", 64'(acc_log[base]), 64'd5);
      chk("t4_acc1", 64'(acc_log[base + 1]), 64'd25);
      chk("t4_gap",  64'(pcyc[base + 1] - pcyc[base]), 64'd2);
    end

    // clr mid-vector drops partial sum and the element offered with clr
    drive(1'b1, 8'd1, 8'd1, 4'd4, 1'b0);
    drive(1'b1, 8'd1, 8'd1, 4'd4, 1'b0);
    @(negedge clk); clr = 1'b1; in_valid = 1'b1; a_in = 8'd9; b_in = 8'd9;
    @(negedge clk); clr = 1'b0; in_valid = 1'b0;
    chk("t5_clr_acc",  64'(m_acc_out), 64'd0);
    chk("t5_clr_busy", 64'(m_busy), 64'd0);
    chk("t5_clr_stk",  64'(s_ovf_sticky), 64'd0);
    base = pulses;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd1, 8'd1, 4'd4, 1'b0);
    idle(4);
    chk("t5_pulses", 64'(pulses - base), 64'd1);
    chk("t5_acc",    64'(m_acc_out), 64'd4);
    chk("t5_sticky", 64'(m_ovf_sticky), 64'd0);

    // vec_len above MAX_LEN clamps to 8
    for (int i = 0; i < 8; i++) drive(1'b1, 8'd1, 8'd1, 4'd12, 1'b0);
    wait_result(n);
    chk("maxlen_latency", 64'(n), 64'd2);
    chk("maxlen_acc",     64'(m_acc_out), 64'd8);

    // vec_len 0 behaves as 1; forwarding tracks inputs one cycle later
    drive(1'b1, 8'd6, 8'd7, 4'd0, 1'b0);
    @(negedge clk);
    chk("t6_aout", 64'(m_a_out), 64'd6);
    chk("t6_bout", 64'(m_b_out), 64'd7);
    chk("t6_vout", 64'(m_valid_out), 64'd1);
    in_valid = 1'b0; a_in = 8'h5A; b_in = 8'hA5;
    @(negedge clk);
    chk("t6_rv",    64'(m_result_valid), 64'd1);
    chk("t6_acc",   64'(m_acc_out), 64'd42);
    chk("t6_aout2", 64'(m_a_out), 64'h5A);
    chk("t6_bout2", 64'(m_b_out), 64'hA5);
    chk("t6_vout2", 64'(m_valid_out), 64'd0);

    // Async reset in the middle of a vector
    drive(1'b1, 8'd3, 8'd3, 4'd4, 1'b0);
    drive(1'b1, 8'd3, 8'd3, 4'd4, 1'b0);
    #2;
    chk("ar_busy_pre", 64'(m_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_acc",   64'(m_acc_out), 64'd0);
    chk("ar_acc16", 64'(s_acc_out), 64'd0);
    chk("ar_busy",  64'(m_busy), 64'd0);
    chk("ar_aout",  64'(m_a_out), 64'd0);
    chk("ar_vout",  64'(m_valid_out), 64'd0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    idle(3);
    chk("ar_busy_after", 64'(m_busy), 64'd0);
    chk("ar_rv_after",   64'(m_result_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
